// File: rtl/rv_pkg.sv
// ============================================================================
// rv_pkg : shared RISC-V opcodes, next-PC select codes, fault causes and FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] PCS_SEQ  = 2'b00;
  localparam logic [1:0] PCS_BR   = 2'b01;
  localparam logic [1:0] PCS_JAL  = 2'b10;
  localparam logic [1:0] PCS_JALR = 2'b11;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_FAULT = 2'd3
  } ifu_state_t;

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// next_pc_calc : combinational next-PC mux with target misalignment check
// Rev 1.0
// ============================================================================
`default_nettype none

module next_pc_calc
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [1:0]      i_pcs,
  input  logic            i_br_taken,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_alu_res,
  output logic [XLEN-1:0] o_npc,
  output logic            o_misalign
);

  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_rel;

  assign w_seq = i_pc + XLEN'(4);
  assign w_rel = i_pc + i_imm;

  always_comb begin
    o_npc = w_seq;
    case (i_pcs)
      PCS_SEQ:  o_npc = w_seq;
      PCS_BR:   o_npc = i_br_taken ? w_rel : w_seq;
      PCS_JAL:  o_npc = w_rel;
      PCS_JALR: o_npc = i_alu_res & ~XLEN'(1);
      default:  o_npc = w_seq;
    endcase
  end

  assign o_misalign = |o_npc[1:0];

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// instruction_fetch_unit : PC owner, IMEM fetch handshake, instruction decode slices
// Rev 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit
  import rv_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              IMEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_valid,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_stage_done,
  input  logic [1:0]      i_pcs,
  input  logic            i_br_taken,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_alu_res,
  output logic            o_instr_valid,
  output logic [31:0]     o_instr,
  output logic [6:0]      o_op_code,
  output logic [2:0]      o_funct_3,
  output logic [6:0]      o_funct_7,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_pc_out,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_fault,
  output logic [1:0]      o_fault_cause
);

  localparam int             c_cnt_w    = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(IMEM_TIMEOUT - 1);

  ifu_state_t         r_state;
  ifu_state_t         w_state_nxt;
  logic [XLEN-1:0]    r_pc;
  logic [31:0]        r_instr;
  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_fault;
  logic [1:0]         r_fault_cause;

  logic [XLEN-1:0]    w_npc;
  logic               w_misalign;
  logic               w_capture;
  logic               w_timeout;
  logic               w_pc_load;
  logic               w_misfault;

  next_pc_calc #(.XLEN(XLEN)) u_next_pc_calc (
    .i_pc       (r_pc),
    .i_pcs      (i_pcs),
    .i_br_taken (i_br_taken),
    .i_imm      (i_imm),
    .i_alu_res  (i_alu_res),
    .o_npc      (w_npc),
    .o_misalign (w_misalign)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_pc_load   = 1'b0;
    w_misfault  = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        // A response arriving on the last allowed cycle beats the timeout.
        if (i_imem_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (r_wait_cnt == c_cnt_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_FAULT;
        end
      end
      S_ISSUE: begin
        if (i_stage_done) begin
          if (w_misalign) begin
            w_misfault  = 1'b1;
            w_state_nxt = S_FAULT;
          end else begin
            w_pc_load   = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= NOP;
      r_wait_cnt    <= '0;
      r_fault       <= 1'b0;
      r_fault_cause <= FC_NONE;
    end else begin
      r_state <= w_state_nxt;
      if (w_pc_load) r_pc <= w_npc;
      if (w_capture) r_instr <= i_imem_rdata;
      if ((r_state == S_FETCH) && !w_capture && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_timeout) begin
        r_fault       <= 1'b1;
        r_fault_cause <= FC_TIMEOUT;
      end else if (w_misfault) begin
        r_fault       <= 1'b1;
        r_fault_cause <= FC_MISALIGN;
      end
    end
  end

  // Request is state-decoded so an async reset drops it without waiting for a clock.
  assign o_imem_req    = (r_state == S_FETCH);
  assign o_imem_addr   = r_pc;
  assign o_instr_valid = (r_state == S_ISSUE);
  assign o_instr       = r_instr;
  assign o_op_code     = r_instr[6:0];
  assign o_funct_3     = r_instr[14:12];
  assign o_funct_7     = r_instr[31:25];
  assign o_rs1         = r_instr[19:15];
  assign o_rs2         = r_instr[24:20];
  assign o_rd          = r_instr[11:7];
  assign o_pc_out      = r_pc;
  assign o_pc_plus4    = r_pc + XLEN'(4);
  assign o_fault       = r_fault;
  assign o_fault_cause = r_fault_cause;

endmodule

`default_nettype wire
